// File: rtl/qsm_wb_sequencer.sv
// qsm_wb_sequencer: Wishbone pipelined initiator that triggers one QSM channel,
// polls its status until done and streams the readout memory as 16-bit beats.
// Optional poll timeout abort: define QSM_POLL_TIMEOUT_EN.
module qsm_wb_sequencer #(
  parameter int CHANNEL       = 0,
  parameter int POLL_GAP      = 16,
  parameter int TIMEOUT_POLLS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  last_reg_adr_i,
  input  logic [3:0]  max_dim_no_i,
  input  logic [9:0]  read_delay_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [10:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i,
  output logic [15:0] data_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic [3:0]  dim_count_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CTRL,
    S_POLL_WAIT,
    S_POLL_RD,
    S_MEM_RD,
    S_OUT,
    S_FIN,
    S_ERR
  } state_t;

  localparam logic [10:0] CTRL_ADR =
    (CHANNEL == 1) ? 11'h008 : 11'h000;
  localparam logic [10:0] STAT_ADR =
    (CHANNEL == 1) ? 11'h00C : 11'h004;
  localparam logic [10:0] MEM_BASE =
    (CHANNEL == 1) ? 11'h600 : 11'h400;
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  state_t      state_q;
  state_t      state_d;
  logic        acc_q;
  logic [15:0] gap_q;
  logic [3:0]  lr_q;
  logic [3:0]  md_q;
  logic [9:0]  rd_q;
  logic [7:0]  idx_q;
  logic [7:0]  n_q;
  logic [15:0] data_q;
  logic [3:0]  dim_q;
  logic [1:0]  code_q;

  logic        code_set;
  logic [1:0]  code_d;
  logic        in_bus;
  logic        start_ok;
  logic        st_ack;
  logic        mem_ack;
  logic        st_done;
  logic        st_bad;
  logic [3:0]  st_dim;
  logic [4:0]  lr_p1;
  logic [8:0]  prod;
  logic [7:0]  n_calc;
  logic [7:0]  idx_nxt;
  logic        poll_to;
  logic        unused_bits;

  assign in_bus = (state_q == S_WR_CTRL) ||
                  (state_q == S_POLL_RD) ||
                  (state_q == S_MEM_RD);
  assign start_ok = (state_q == S_IDLE) && start_i;
  assign st_ack   = (state_q == S_POLL_RD) &&
                    wb_ack_i && !wb_err_i;
  assign mem_ack  = (state_q == S_MEM_RD) &&
                    wb_ack_i && !wb_err_i;

  assign st_done = wb_dat_i[1];
  assign st_bad  = wb_dat_i[2] | wb_dat_i[3];
  assign st_dim  = wb_dat_i[7:4];

  // Words to fetch: registers per DIM times DIM count, capped at 128
  assign lr_p1  = {1'b0, lr_q} + 5'd1;
  assign prod   = {4'b0, lr_p1} * {5'b0, st_dim};
  assign n_calc = (prod >= 9'd128) ? 8'd128 : prod[7:0];

  assign idx_nxt     = idx_q + 8'd1;
  assign unused_bits = ^wb_dat_i[31:16];

`ifdef QSM_POLL_TIMEOUT_EN
  localparam logic [15:0] TO_POLLS = 16'(TIMEOUT_POLLS);

  logic [15:0] poll_q;

  assign poll_to = (poll_q + 16'd1) >= TO_POLLS;

  // Count not-done status replies since the sequence started
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      poll_q <= '0;
    end else if (start_ok) begin
      poll_q <= '0;
    end else if (st_ack && !st_done) begin
      poll_q <= poll_q + 16'd1;
    end
  end
`else
  assign poll_to = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and error classification
  always_comb begin
    state_d  = state_q;
    code_set = 1'b0;
    code_d   = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        if (wb_ack_i) state_d = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (gap_q == GAP_LAST) state_d = S_POLL_RD;
      end
      S_POLL_RD: begin
        if (wb_ack_i) begin
          if (!st_done) begin
            if (poll_to) begin
              state_d  = S_ERR;
              code_set = 1'b1;
              code_d   = 2'b11;
            end else begin
              state_d = S_POLL_WAIT;
            end
          end else if (st_bad) begin
            state_d  = S_ERR;
            code_set = 1'b1;
            code_d   = 2'b10;
          end else if (n_calc == 8'd0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_MEM_RD;
          end
        end
      end
      S_MEM_RD: begin
        if (wb_ack_i) state_d = S_OUT;
      end
      S_OUT: begin
        if (data_ready_i) begin
          state_d = (idx_nxt == n_q) ? S_FIN : S_MEM_RD;
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (in_bus && wb_err_i) begin
      state_d  = S_ERR;
      code_set = 1'b1;
      code_d   = 2'b01;
    end
  end

  // Request phase: strobe until the slave takes it, then wait for ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= 1'b0;
    end else if (!in_bus || wb_ack_i || wb_err_i) begin
      acc_q <= 1'b0;
    end else if (wb_stb_o && !wb_stall_i) begin
      acc_q <= 1'b1;
    end
  end

  // Idle spacing between status reads
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_q <= '0;
    end else if (state_q != S_POLL_WAIT) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_q + 16'd1;
    end
  end

  // Parameter latch at start and sticky error code
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lr_q   <= '0;
      md_q   <= '0;
      rd_q   <= '0;
      code_q <= '0;
    end else begin
      if (start_ok) begin
        lr_q   <= last_reg_adr_i;
        md_q   <= max_dim_no_i;
        rd_q   <= read_delay_i;
        code_q <= 2'b00;
      end
      if (code_set) code_q <= code_d;
    end
  end

  // Readout bookkeeping: word count, index, captured word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dim_q  <= '0;
      n_q    <= '0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      if (st_ack && st_done && !st_bad) begin
        dim_q <= st_dim;
        n_q   <= n_calc;
        idx_q <= '0;
      end
      if (mem_ack) data_q <= wb_dat_i[15:0];
      if ((state_q == S_OUT) && data_ready_i) begin
        idx_q <= idx_nxt;
      end
    end
  end

  // Bus and status outputs decoded from state
  always_comb begin
    wb_cyc_o     = in_bus;
    wb_stb_o     = in_bus && !acc_q;
    wb_we_o      = 1'b0;
    wb_adr_o     = '0;
    wb_dat_o     = '0;
    data_valid_o = (state_q == S_OUT);
    busy_o       = (state_q != S_IDLE) &&
                   (state_q != S_FIN) &&
                   (state_q != S_ERR);
    done_o       = (state_q == S_FIN);
    err_o        = (state_q == S_ERR);
    unique case (state_q)
      S_WR_CTRL: begin
        wb_we_o  = 1'b1;
        wb_adr_o = CTRL_ADR;
        wb_dat_o = {12'b0, rd_q, md_q, lr_q, 2'b10};
      end
      S_POLL_RD: begin
        wb_adr_o = STAT_ADR;
      end
      S_MEM_RD: begin
        wb_adr_o = MEM_BASE + {2'b00, idx_q[6:0], 2'b00};
      end
      default: begin
        wb_adr_o = '0;
      end
    endcase
  end

  assign wb_sel_o    = 4'b1111;
  assign data_o      = data_q;
  assign dim_count_o = dim_q;
  assign err_code_o  = code_q;

endmodule
